// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD-to-int32 loader:
//   state_t      - loader FSM encoding (IDLE, ACCUM, HOLD)
//   BCD_MAX      - largest legal BCD digit value
//   POS_MAG_MAX  - largest magnitude representable as a positive int32
//   NEG_MAG_MAX  - largest magnitude representable as a negative int32
//   bcd_digit_value - maps an illegal digit (above BCD_MAX) to 0
// ---------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0]  BCD_MAX     = 4'd9;
    localparam logic [35:0] POS_MAG_MAX = 36'd2147483647;
    localparam logic [35:0] NEG_MAG_MAX = 36'd2147483648;

    // Illegal digits contribute nothing to the magnitude.
    function automatic logic [3:0] bcd_digit_value(input logic [3:0] d);
        return (d > BCD_MAX) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/bcd_mac10.sv
// ---------------------------------------------------------------------------
// bcd_mac10
// Combinational multiply-by-ten-and-add for decimal accumulation.
//   acc      [31:0] in  - running magnitude
//   digit    [3:0]  in  - digit value to add (already sanitised)
//   sign            in  - 1 selects the negative magnitude limit
//   result   [35:0] out - acc*10 + digit, full 36-bit width
//   exceeded        out - result is beyond the int32 range for this sign
// ---------------------------------------------------------------------------
module bcd_mac10
    import bcd_pkg::*;
(
    input  logic [31:0] acc,
    input  logic [3:0]  digit,
    input  logic        sign,
    output logic [35:0] result,
    output logic        exceeded
);

    logic [35:0] acc_w;

    always_comb begin
        acc_w    = {4'd0, acc};
        // acc*10 built from two shifts, no multiplier.
        result   = (acc_w << 3) + (acc_w << 1) + {32'd0, digit};
        exceeded = sign ? (result > NEG_MAG_MAX) : (result > POS_MAG_MAX);
    end

endmodule

// File: rtl/bcd_to_int32_loader.sv
// ---------------------------------------------------------------------------
// bcd_to_int32_loader
// Accepts a signed decimal number as a stream of BCD digits (most
// significant first) and produces the two's-complement 32-bit value.
//
// Optional build macro: BCD_LOADER_SAT_EN
//   defined   - out-of-range results saturate to 0x7FFFFFFF / 0x80000000
//   undefined - out-of-range results wrap modulo 2^32
//   overflow is flagged the same way in both builds.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high
//   digit_valid  in   digit/sign_in/last are valid
//   digit_ready  out  loader can accept a digit (IDLE, ACCUM)
//   digit [3:0]  in   BCD digit
//   sign_in      in   1 = negative, sampled with the first digit only
//   last         in   current digit ends the number
//   out_valid    out  result held (HOLD)
//   out_ready    in   consumer takes the result
//   decimal[31:0]out  two's-complement result
//   overflow     out  sticky: magnitude out of range or too many digits
//   bad_digit    out  sticky: a digit above 9 was seen
// ---------------------------------------------------------------------------
module bcd_to_int32_loader
    import bcd_pkg::*;
#(
    parameter int MAX_DIGITS = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               digit_valid,
    output logic               digit_ready,
    input  logic [3:0]         digit,
    input  logic               sign_in,
    input  logic               last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] decimal,
    output logic               overflow,
    output logic               bad_digit
);

    // Count saturates one above the limit, so this width always suffices.
    localparam int CNT_W = $clog2(MAX_DIGITS + 2);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    logic [31:0]      magnitude;
    logic [CNT_W-1:0] count;
    logic             sign_q;

    logic             accept;
    logic [3:0]       digit_eff;
    logic             digit_bad;
    logic [35:0]      mac_result;
    logic             mac_exceeded;
    logic [CNT_W-1:0] count_inc;

    logic [31:0]      magnitude_n;
    logic [CNT_W-1:0] count_n;
    logic             sign_n;
    logic             overflow_n;
    logic             bad_digit_n;

    function automatic logic signed [31:0] apply_sign(input logic [31:0] mag,
                                                      input logic        neg);
        // -0 wraps to 0, so negative zero needs no special case.
        return neg ? -$signed(mag) : $signed(mag);
    endfunction

`ifdef BCD_LOADER_SAT_EN
    function automatic logic signed [31:0] saturate(input logic signed [31:0] val,
                                                    input logic              neg,
                                                    input logic              ovf);
        if (!ovf)
            return val;
        return neg ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    endfunction
`endif

    assign accept    = digit_valid & digit_ready;
    assign digit_eff = bcd_digit_value(digit);
    assign digit_bad = (digit > BCD_MAX);
    assign count_inc = (count > CNT_LIMIT) ? count : count + CNT_ONE;

    bcd_mac10 u_mac10 (
        .acc      (magnitude),
        .digit    (digit_eff),
        .sign     (sign_q),
        .result   (mac_result),
        .exceeded (mac_exceeded)
    );

    // Next-state values of the number being assembled; unchanged unless a
    // digit is accepted.
    always_comb begin
        magnitude_n = magnitude;
        count_n     = count;
        sign_n      = sign_q;
        overflow_n  = overflow;
        bad_digit_n = bad_digit;
        if (accept) begin
            if (state == IDLE) begin
                magnitude_n = {28'd0, digit_eff};
                count_n     = CNT_ONE;
                sign_n      = sign_in;
                overflow_n  = (CNT_ONE > CNT_LIMIT);
                bad_digit_n = digit_bad;
            end else begin
                magnitude_n = mac_result[31:0];
                count_n     = count_inc;
                // Any carry into the top nibble is out of range as well.
                overflow_n  = overflow | mac_exceeded | (|mac_result[35:32])
                              | (count_inc > CNT_LIMIT);
                bad_digit_n = bad_digit | digit_bad;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            magnitude   <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            decimal     <= '0;
            overflow    <= 1'b0;
            bad_digit   <= 1'b0;
            out_valid   <= 1'b0;
            digit_ready <= 1'b1;
        end else begin
            magnitude <= magnitude_n;
            count     <= count_n;
            sign_q    <= sign_n;
            overflow  <= overflow_n;
            bad_digit <= bad_digit_n;
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (last) begin
                            state       <= HOLD;
                            out_valid   <= 1'b1;
                            digit_ready <= 1'b0;
`ifdef BCD_LOADER_SAT_EN
                            decimal     <= saturate(apply_sign(magnitude_n, sign_n),
                                                    sign_n, overflow_n);
`else
                            decimal     <= apply_sign(magnitude_n, sign_n);
`endif
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid   <= 1'b0;
                        digit_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid   <= 1'b0;
                    digit_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_int32_loader.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_int32_loader
// Directed self-checking bench for bcd_to_int32_loader. Inputs change 1 time
// unit after the rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_bcd_to_int32_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        digit_valid;
    logic        digit_ready;
    logic [3:0]  digit;
    logic        sign_in;
    logic        last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] decimal;
    logic        overflow;
    logic        bad_digit;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_to_int32_loader #(.MAX_DIGITS(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .digit       (digit),
        .sign_in     (sign_in),
        .last        (last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .decimal     (decimal),
        .overflow    (overflow),
        .bad_digit   (bad_digit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one digit and hold it until accepted (bounded wait).
    task automatic put(input logic [3:0] d, input logic s, input logic l);
        int n;
        n = 0;
        while (!digit_ready && n < 20) begin
            tick();
            n++;
        end
        if (!digit_ready)
            check("ready_timeout", {31'd0, digit_ready}, 32'd1);
        digit_valid = 1'b1;
        digit       = d;
        sign_in     = s;
        last        = l;
        tick();
        digit_valid = 1'b0;
        sign_in     = 1'b0;
        last        = 1'b0;
    endtask

    task automatic send_num(input string s, input logic neg);
        for (int i = 0; i < s.len(); i++)
            put(4'(s[i] - 8'd48), (i == 0) ? neg : 1'b0, (i == s.len() - 1));
    endtask

    // Called right after the last digit: result must already be valid.
    task automatic expect_result(input string tag, input logic [31:0] dec,
                                 input logic ovf, input logic bad);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_dec"}, decimal, dec);
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ovf});
        check({tag, "_bad"}, {31'd0, bad_digit}, {31'd0, bad});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_released"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready"}, {31'd0, digit_ready}, 32'd1);
    endtask

    initial begin
        reset       = 1'b1;
        digit_valid = 1'b0;
        digit       = 4'd0;
        sign_in     = 1'b0;
        last        = 1'b0;
        out_ready   = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_ready", {31'd0, digit_ready}, 32'd1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_dec", decimal, 32'h0000_0000);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_bad", {31'd0, bad_digit}, 32'd0);

        // 123
        send_num("123", 1'b0);
        expect_result("pos123", 32'h0000_007B, 1'b0, 1'b0);

        // -2147483648 is the most negative int32, in range
        send_num("2147483648", 1'b1);
        expect_result("min_int", 32'h8000_0000, 1'b0, 1'b0);

        // +2147483647 is the largest positive int32, in range
        send_num("2147483647", 1'b0);
        expect_result("max_int", 32'h7FFF_FFFF, 1'b0, 1'b0);

        // +2147483648 overflows
`ifdef BCD_LOADER_SAT_EN
        send_num("2147483648", 1'b0);
        expect_result("pos_ovf", 32'h7FFF_FFFF, 1'b1, 1'b0);
`else
        send_num("2147483648", 1'b0);
        expect_result("pos_ovf", 32'h8000_0000, 1'b1, 1'b0);
`endif

        // -2147483649 overflows; wrapped value is 0x7FFFFFFF
`ifdef BCD_LOADER_SAT_EN
        send_num("2147483649", 1'b1);
        expect_result("neg_ovf", 32'h8000_0000, 1'b1, 1'b0);
`else
        send_num("2147483649", 1'b1);
        expect_result("neg_ovf", 32'h7FFF_FFFF, 1'b1, 1'b0);
`endif

        // 11 digits exceed the digit limit even though the value is 1
`ifdef BCD_LOADER_SAT_EN
        send_num("00000000001", 1'b0);
        expect_result("too_many", 32'h7FFF_FFFF, 1'b1, 1'b0);
`else
        send_num("00000000001", 1'b0);
        expect_result("too_many", 32'h0000_0001, 1'b1, 1'b0);
`endif

        // 1, 0xA, 5 -> 105 with bad_digit; overflow cleared from before
        put(4'd1, 1'b0, 1'b0);
        put(4'hA, 1'b0, 1'b0);
        put(4'd5, 1'b0, 1'b1);
        expect_result("bad_dig", 32'h0000_0069, 1'b0, 1'b1);

        // Sign taken from first digit only, idle gaps inside ACCUM: -123
        put(4'd1, 1'b1, 1'b0);
        repeat (3) tick();
        check("gap_no_valid", {31'd0, out_valid}, 32'd0);
        put(4'd2, 1'b0, 1'b0);
        tick();
        put(4'd3, 1'b0, 1'b1);
        expect_result("neg123", 32'hFFFF_FF85, 1'b0, 1'b0);

        // Negative zero
        send_num("0", 1'b1);
        expect_result("neg_zero", 32'h0000_0000, 1'b0, 1'b0);

        // Hold for 5 cycles with a digit pending: nothing may move
        send_num("42", 1'b0);
        digit_valid = 1'b1;
        digit       = 4'd5;
        last        = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_dec", decimal, 32'h0000_002A);
            check("hold_ready", {31'd0, digit_ready}, 32'd0);
            tick();
        end
        digit_valid = 1'b0;
        last        = 1'b0;
        expect_result("hold", 32'h0000_002A, 1'b0, 1'b0);
        tick();
        check("hold_no_accept", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of ACCUM, then a clean single digit
        put(4'd9, 1'b1, 1'b0);
        put(4'd9, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_ready", {31'd0, digit_ready}, 32'd1);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        send_num("7", 1'b0);
        expect_result("after_rst", 32'h0000_0007, 1'b0, 1'b0);

        // Reset while holding a result with sticky flags
        put(4'hF, 1'b0, 1'b1);
        check("hrst_valid_pre", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("hrst_valid", {31'd0, out_valid}, 32'd0);
        check("hrst_bad", {31'd0, bad_digit}, 32'd0);
        check("hrst_dec", decimal, 32'h0000_0000);
        check("hrst_ready", {31'd0, digit_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
